mem_bist_master: RTL and testbench

MEM_BIST_MASTER -- requirements
Module: mem_bist_master

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/mem_bist_master.sv | 176 +++++++++++++++++
 tb/tb_mem_bist_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory BIST master: FSM state encoding, default
// parameter values and the per-address test pattern.
package mem_pkg;

    localparam int          DEF_WIDTH      = 16;
    localparam int          DEF_ADDR_WIDTH = 6;
    localparam logic [15:0] DEF_SEED       = 16'hA5C3;
    localparam int          DEF_TIMEOUT    = 8;

    // Widest data word the pattern helper supports; callers truncate to WIDTH.
    localparam int          PAT_MAX_W      = 64;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_e;

    // pat(a) = seed XOR zero-extended address.
    function automatic logic [PAT_MAX_W-1:0] mem_pat(
        input logic [PAT_MAX_W-1:0] seed,
        input logic [PAT_MAX_W-1:0] addr
    );
        return seed ^ addr;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Handshake wait counter: cleared at request issue, counts wait cycles without
// an acknowledge, flags the cycle whose increment would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Look-ahead compare so the FSM leaves WAIT after exactly TIMEOUT idle cycles.
    assign expired_o = (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes pat(a) to every address, reads all of them back,
// and reports mismatch count, first failing address and handshake timeout.
module mem_bist_master
    import mem_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEF_SEED),
    parameter int               TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  valid_o,
    output logic                  wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic [WIDTH-1:0]      rdata_i,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o
);

    // Handshake: valid_o is a single-cycle request pulse in *_ISSUE; addr_o,
    // wr_rd_en_o and wdata_o stay stable until ready_i is seen in *_WAIT, and
    // that edge completes the transfer (read data is sampled at the same edge).
    // ready_i is ignored outside the WAIT states.

    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [ADDR_WIDTH-1:0] fail_addr_d;
    logic [ADDR_WIDTH:0]   err_cnt_q;
    logic [ADDR_WIDTH:0]   err_cnt_d;
    logic                  timeout_q;
    logic                  timeout_d;

    logic                  tmr_clear;
    logic                  tmr_en;
    logic                  tmr_expired;
    logic [WIDTH-1:0]      pat_w;
    logic                  last_addr;
    logic                  wr_phase;

    assign pat_w     = WIDTH'(mem_pat(PAT_MAX_W'(SEED), PAT_MAX_W'(addr_q)));
    assign last_addr = (addr_q == ADDR_LAST);
    assign wr_phase  = (state_q == WR_ISSUE) || (state_q == WR_WAIT);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (tmr_clear),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        timeout_d   = timeout_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = WR_ISSUE;
                    addr_d      = '0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    timeout_d   = 1'b0;
                end
            end

            WR_ISSUE: begin
                tmr_clear = 1'b1;
                state_d   = WR_WAIT;
            end

            WR_WAIT: begin
                if (ready_i) begin
                    if (last_addr) begin
                        addr_d  = '0;
                        state_d = RD_ISSUE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = WR_ISSUE;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end

            RD_ISSUE: begin
                tmr_clear = 1'b1;
                state_d   = RD_WAIT;
            end

            RD_WAIT: begin
                if (ready_i) begin
                    if (rdata_i != pat_w) begin
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        // err_cnt_q still zero means this is the first failure of the run.
                        if (err_cnt_q == '0) begin
                            fail_addr_d = addr_q;
                        end
                    end
                    if (last_addr) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            timeout_q   <= timeout_d;
        end
    end

    // All outputs decode from registered state, so reset clears them at once.
    assign valid_o     = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    assign wr_rd_en_o  = wr_phase;
    assign addr_o      = addr_q;
    assign wdata_o     = wr_phase ? pat_w : '0;
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign pass_o      = done_o && (err_cnt_q == '0) && !timeout_q;
    assign timeout_o   = timeout_q;
    assign err_cnt_o   = err_cnt_q;
    assign fail_addr_o = fail_addr_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: a memory responder with random latency and
// injectable read corruption, plus a sweep-level reference of the expected run.
module tb_mem_bist_master;

    localparam int          W     = 16;
    localparam int          AW    = 6;
    localparam int          DEPTH = 64;
    localparam int          TO    = 8;
    localparam logic [15:0] SEED  = 16'hA5C3;
    localparam int          EW    = 1 + AW + W;

    // ---------------- clock / reset / DUT ----------------
    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b0;
    logic          start_i = 1'b0;
    logic          valid_o;
    logic          wr_rd_en_o;
    logic [AW-1:0] addr_o;
    logic [W-1:0]  wdata_o;
    logic [W-1:0]  rdata_i;
    logic          ready_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic          timeout_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] fail_addr_o;

    always #5 clk_i = ~clk_i;

    mem_bist_master #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .SEED       (SEED),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .valid_o     (valid_o),
        .wr_rd_en_o  (wr_rd_en_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_i     (rdata_i),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .timeout_o   (timeout_o),
        .err_cnt_o   (err_cnt_o),
        .fail_addr_o (fail_addr_o)
    );

    // ---------------- scoreboard state ----------------
    int             n_cmp = 0;
    int             n_err = 0;
    logic [EW-1:0]  exp_q[$];
    int             exp_err;
    int             exp_fail;
    bit             exp_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int a);
        return W'(32'(SEED) ^ a);
    endfunction

    // ---------------- memory responder ----------------
    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] bad_val [DEPTH];
    bit           bad     [DEPTH];
    int           max_lat  = 0;
    int           stall_at = -1;
    int           resp_txn;
    int           lat_cnt;
    int           next_lat;
    bit           pend;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_i  <= 1'b0;
            rdata_i  <= '0;
            pend     <= 1'b0;
            lat_cnt  <= 0;
            resp_txn <= 0;
            next_lat <= 0;
        end else begin
            ready_i  <= 1'b0;
            next_lat <= $urandom_range(0, max_lat);
            if (start_i && !busy_o) begin
                resp_txn <= 0;
            end
            if (valid_o) begin
                resp_txn <= resp_txn + 1;
                if (wr_rd_en_o) begin
                    mem[addr_o] <= wdata_o;
                end else begin
                    rdata_i <= bad[addr_o] ? bad_val[addr_o] : mem[addr_o];
                end
                if (stall_at < 0 || resp_txn < stall_at) begin
                    if (next_lat == 0) begin
                        ready_i <= 1'b1;
                    end else begin
                        pend    <= 1'b1;
                        lat_cnt <= next_lat;
                    end
                end
            end else if (pend) begin
                if (lat_cnt == 1) begin
                    ready_i <= 1'b1;
                    pend    <= 1'b0;
                end
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // ---------------- request monitor ----------------
    always @(negedge clk_i) begin
        if (rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_request", 64'(valid_o), 64'(0));
            end else begin
                check("request", 64'({wr_rd_en_o, addr_o, (wr_rd_en_o ? wdata_o : W'(0))}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- reference model ----------------
    // A run is a write sweep then a read sweep; a stalled memory truncates it
    // after the stalled request, and only completed reads can count as errors.
    task automatic build_model(input int stall);
        int ntx;
        int a;
        bit wr;
        exp_q.delete();
        ntx = (stall < 0) ? 2 * DEPTH : stall + 1;
        for (int t = 0; t < ntx; t++) begin
            wr = (t < DEPTH);
            a  = wr ? t : t - DEPTH;
            exp_q.push_back({wr, AW'(a), (wr ? pat(a) : W'(0))});
        end
        exp_err  = 0;
        exp_fail = 0;
        exp_to   = (stall >= 0);
        for (int t = DEPTH; t < ntx; t++) begin
            a = t - DEPTH;
            if ((stall < 0 || t < stall) && bad[a] && bad_val[a] !== pat(a)) begin
                if (exp_err == 0) exp_fail = a;
                exp_err++;
            end
        end
    endtask

    task automatic clear_bad();
        for (int i = 0; i < DEPTH; i++) begin
            bad[i]     = 1'b0;
            bad_val[i] = '0;
        end
    endtask

    task automatic run_test(input string tag, input int lat, input int stall,
                            input bit poke, input int exp_cycles);
        int cyc;
        max_lat  = lat;
        stall_at = stall;
        build_model(stall);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 3000) begin
            start_i = (poke && busy_o && $urandom_range(0, 7) == 0);
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        check({tag, "_done"}, 64'(done_o), 64'(1));
        if (exp_cycles > 0) check({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        check({tag, "_err_cnt"},   64'(err_cnt_o),   64'(exp_err));
        check({tag, "_fail_addr"}, 64'(fail_addr_o), 64'(exp_fail));
        check({tag, "_timeout"},   64'(timeout_o),   64'(exp_to));
        check({tag, "_pass"},      64'(pass_o),      64'(exp_err == 0 && !exp_to));
        repeat (12) @(negedge clk_i);
        check({tag, "_all_requests"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_done_held"}, 64'({done_o, busy_o, valid_o}), 64'(3'b100));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int  a;
        int  nb;
        int  cyc;
        bit  found;

        clear_bad();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", 64'({valid_o, wr_rd_en_o, addr_o, wdata_o, busy_o, done_o,
                                    pass_o, timeout_o, err_cnt_o, fail_addr_o}), 64'(0));
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_no_request", 64'({valid_o, busy_o, done_o}), 64'(0));

        // Ideal memory: 128 two-cycle transactions.
        run_test("ideal", 0, -1, 1'b0, 4 * DEPTH);

        bad[5] = 1'b1; bad_val[5] = 16'h0000;
        run_test("word5", 0, -1, 1'b0, 4 * DEPTH);
        clear_bad();

        bad[7] = 1'b1; bad_val[7] = 16'h0000;
        bad[20] = 1'b1; bad_val[20] = 16'h0000;
        run_test("word7_20", 0, -1, 1'b0, 4 * DEPTH);
        clear_bad();

        // Memory stops acknowledging at the third write.
        run_test("timeout", 0, 2, 1'b0, 13);

        // start_i pulsed while busy must not disturb the sweep.
        bad[7] = 1'b1; bad_val[7] = 16'h1234;
        run_test("busy_start", 2, -1, 1'b1, 0);
        clear_bad();

        // Reset during RD_WAIT at address 30.
        max_lat  = 0;
        stall_at = -1;
        build_model(-1);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 600) begin
            found = busy_o && !valid_o && !wr_rd_en_o && (addr_o == AW'(30));
            if (!found) begin
                @(negedge clk_i);
                cyc++;
            end
        end
        check("reached_rd_wait_30", 64'(found), 64'(1));
        #2;
        rst_i = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outputs", 64'({valid_o, wr_rd_en_o, addr_o, wdata_o, busy_o, done_o,
                                          pass_o, timeout_o, err_cnt_o, fail_addr_o}), 64'(0));
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("after_reset_quiet", 64'({valid_o, busy_o, done_o}), 64'(0));
        run_test("rerun", 0, -1, 1'b0, 4 * DEPTH);

        // Randomized runs: random latency, random corrupted words, random start pokes.
        for (int r = 0; r < 4; r++) begin
            clear_bad();
            nb = $urandom_range(0, 4);
            for (int k = 0; k < nb; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                bad[a]     = 1'b1;
                bad_val[a] = pat(a) ^ W'($urandom_range(1, 65535));
            end
            run_test($sformatf("rand%0d", r), $urandom_range(0, 3), -1,
                     1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
